// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status from ID/EX/MEM in, stage
// hold/flush/bubble controls, forwarding selects and perf counters out.
interface ex_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_reg_write;
  logic              idex_mem_read;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic              ex_branch_taken;
  logic              mc_start;
  logic              mc_done;
  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              ex_hold;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        state_o;
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, idex_rd, idex_reg_write, idex_mem_read,
           exmem_rd, exmem_reg_write, ex_branch_taken, mc_start, mc_done,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold,
           fwd_a, fwd_b, state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, idex_rd, idex_reg_write, idex_mem_read,
           exmem_rd, exmem_reg_write, ex_branch_taken, mc_start, mc_done,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold,
           fwd_a, fwd_b, state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects, load-use bubbles, branch
// flush sequencing, multi-cycle EX freeze and stall/flush counters.
module ex_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              res,
  ex_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_MC_WAIT = 2'b10
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_flush_left;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_load_use;
  logic        w_pc_hold;
  logic        w_ifid_hold;
  logic        w_ifid_flush;
  logic        w_idex_bubble;
  logic        w_ex_hold;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  // Newest producer wins: EX/MEM result beats MEM/WB result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] ex_rd,
    input logic              ex_wr,
    input logic [REG_AW-1:0] mem_rd,
    input logic              mem_wr
  );
    logic [1:0] sel;
    if (ex_wr && (ex_rd != '0) && (ex_rd == rs)) begin
      sel = 2'b10;
    end else if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_load_use = bus.id_valid & bus.idex_mem_read & bus.idex_reg_write &
                      (bus.idex_rd != '0) &
                      ((bus.idex_rd == bus.id_rs1) | (bus.idex_rd == bus.id_rs2));

  // Forwarding selects for the instruction currently in ID.
  always_comb begin
    w_fwd_a = fwd_sel(bus.id_rs1, bus.idex_rd, bus.idex_reg_write,
                      bus.exmem_rd, bus.exmem_reg_write);
    w_fwd_b = fwd_sel(bus.id_rs2, bus.idex_rd, bus.idex_reg_write,
                      bus.exmem_rd, bus.exmem_reg_write);
  end

  // Mealy hold/flush/bubble decode from current state and inputs.
  always_comb begin
    w_pc_hold     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_ex_hold     = 1'b0;
    if (res) begin
      w_pc_hold = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (bus.mc_start) begin
            w_pc_hold   = ~bus.mc_done;
            w_ifid_hold = ~bus.mc_done;
            w_ex_hold   = ~bus.mc_done;
          end else if (w_load_use) begin
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_bubble = 1'b1;
          end else begin
            w_pc_hold = 1'b0;
          end
        end
        ST_FLUSH: begin
          w_ifid_flush = 1'b1;
        end
        ST_MC_WAIT: begin
          w_pc_hold   = ~bus.mc_done;
          w_ifid_hold = ~bus.mc_done;
          w_ex_hold   = ~bus.mc_done;
        end
        default: begin
          w_pc_hold = 1'b0;
        end
      endcase
    end
  end

  // Sequencer FSM, forwarding registers and performance counters.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= ST_RUN;
      r_flush_left <= 4'd0;
      r_fwd_a      <= 2'b00;
      r_fwd_b      <= 2'b00;
      r_stall_cnt  <= 32'd0;
      r_flush_cnt  <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
            if (FLUSH_CYCLES > 1) begin
              r_state      <= ST_FLUSH;
              r_flush_left <= FLUSH_INIT;
            end else begin
              r_state <= ST_RUN;
            end
          end else if (bus.mc_start && !bus.mc_done) begin
            r_state <= ST_MC_WAIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (r_flush_left <= 4'd1) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_left <= r_flush_left - 4'd1;
          end
        end
        ST_MC_WAIT: begin
          if (bus.mc_done) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_MC_WAIT;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase

      if (w_pc_hold) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end

      // Selects advance only when ID actually moves into EX.
      if (!w_ex_hold && !w_pc_hold) begin
        if (w_idex_bubble) begin
          r_fwd_a <= 2'b00;
          r_fwd_b <= 2'b00;
        end else begin
          r_fwd_a <= w_fwd_a;
          r_fwd_b <= w_fwd_b;
        end
      end
    end
  end

  assign bus.pc_hold     = w_pc_hold;
  assign bus.ifid_hold   = w_ifid_hold;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.ex_hold     = w_ex_hold;
  assign bus.fwd_a       = r_fwd_a;
  assign bus.fwd_b       = r_fwd_b;
  assign bus.state_o     = r_state;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed per-cycle vectors push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_ex_hazard_ctrl;

  typedef struct packed {
    logic [4:0]  ctl;   // {pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [15:0] fc;
  } exp_t;

  localparam logic [4:0] C_NO = 5'b00000;
  localparam logic [4:0] C_LU = 5'b11010;
  localparam logic [4:0] C_BR = 5'b00110;
  localparam logic [4:0] C_FL = 5'b00100;
  localparam logic [4:0] C_MC = 5'b11001;

  logic clk;
  logic res;
  exp_t sb_q[$];
  int   checks;
  int   failures;
  int   vec_no;

  ex_hazard_ctrl_if #(.REG_AW(5)) bus ();

  ex_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("ctl", vec_no, 32'({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble, bus.ex_hold}), 32'(e.ctl));
      cmp("fwd_a", vec_no, 32'(bus.fwd_a), 32'(e.fa));
      cmp("fwd_b", vec_no, 32'(bus.fwd_b), 32'(e.fb));
      cmp("state", vec_no, 32'(bus.state_o), 32'(e.st));
      cmp("stall_cnt", vec_no, bus.stall_cnt, e.sc);
      cmp("flush_cnt", vec_no, 32'(bus.flush_cnt), 32'(e.fc));
    end
  end

  task automatic vec(
    input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] erd, input logic erw, input logic emr,
    input logic [4:0] mrd, input logic mrw,
    input logic br, input logic ms, input logic md,
    input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
    input logic [1:0] st, input logic [31:0] sc, input logic [15:0] fc
  );
    exp_t e;
    @(posedge clk);
    #1;
    vec_no                = vec_no + 1;
    res                   = r;
    bus.id_valid          = v;
    bus.id_rs1            = rs1;
    bus.id_rs2            = rs2;
    bus.idex_rd           = erd;
    bus.idex_reg_write    = erw;
    bus.idex_mem_read     = emr;
    bus.exmem_rd          = mrd;
    bus.exmem_reg_write   = mrw;
    bus.ex_branch_taken   = br;
    bus.mc_start          = ms;
    bus.mc_done           = md;
    e.ctl = ctl; e.fa = fa; e.fb = fb; e.st = st; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [1:0] st, input logic [31:0] sc, input logic [15:0] fc);
    vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        ctl, fa, fb, st, sc, fc);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vec_no   = 0;
    res      = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.idex_rd = 5'd0; bus.idex_reg_write = 1'b0; bus.idex_mem_read = 1'b0;
    bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.mc_start = 1'b0; bus.mc_done = 1'b0;

    // Reset state
    vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NO, 2'b00, 2'b00, 2'b00, 32'd0, 16'd0);
    vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NO, 2'b00, 2'b00, 2'b00, 32'd0, 16'd0);
    idle(C_NO, 2'b00, 2'b00, 2'b00, 32'd0, 16'd0);
    // Load-use on rs2, then the load sits in MEM and rs2 forwards from MEM/WB
    vec(1'b0, 1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 2'b00, 2'b00, 2'b00, 32'd0, 16'd0);
    vec(1'b0, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_NO, 2'b00, 2'b00, 2'b00, 32'd1, 16'd0);
    idle(C_NO, 2'b00, 2'b01, 2'b00, 32'd1, 16'd0);
    // EX/MEM beats MEM/WB; rd=0 in EX falls back to MEM/WB
    vec(1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NO, 2'b00, 2'b00, 2'b00, 32'd1, 16'd0);
    vec(1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NO, 2'b10, 2'b00, 2'b00, 32'd1, 16'd0);
    idle(C_NO, 2'b01, 2'b00, 2'b00, 32'd1, 16'd0);
    // Taken branch: 2-cycle flush, load-use during FLUSH ignored
    vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR, 2'b00, 2'b00, 2'b00, 32'd1, 16'd0);
    vec(1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FL, 2'b00, 2'b00, 2'b01, 32'd1, 16'd1);
    vec(1'b0, 1'b1, 5'd9, 5'd4, 5'd9, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, C_NO, 2'b10, 2'b00, 2'b00, 32'd1, 16'd1);
    // Multi-cycle op: 4 hold cycles, selects frozen until mc_done
    vec(1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MC, 2'b10, 2'b01, 2'b00, 32'd1, 16'd1);
    vec(1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_MC, 2'b10, 2'b01, 2'b10, 32'd2, 16'd1);
    vec(1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_MC, 2'b10, 2'b01, 2'b10, 32'd3, 16'd1);
    vec(1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_MC, 2'b10, 2'b01, 2'b10, 32'd4, 16'd1);
    vec(1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_NO, 2'b10, 2'b01, 2'b10, 32'd5, 16'd1);
    idle(C_NO, 2'b10, 2'b10, 2'b00, 32'd5, 16'd1);
    // Branch wins over mc_start; mc_start with mc_done is single-cycle
    vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_BR, 2'b00, 2'b00, 2'b00, 32'd5, 16'd1);
    idle(C_FL, 2'b00, 2'b00, 2'b01, 32'd5, 16'd2);
    vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NO, 2'b00, 2'b00, 2'b00, 32'd5, 16'd2);
    idle(C_NO, 2'b00, 2'b00, 2'b00, 32'd5, 16'd2);
    // Reset in the middle of MC_WAIT
    vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MC, 2'b00, 2'b00, 2'b00, 32'd5, 16'd2);
    idle(C_MC, 2'b00, 2'b00, 2'b10, 32'd6, 16'd2);
    vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NO, 2'b00, 2'b00, 2'b00, 32'd0, 16'd0);
    // Normal operation after release; rd=0 load never stalls
    vec(1'b0, 1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 2'b00, 2'b00, 2'b00, 32'd0, 16'd0);
    idle(C_NO, 2'b00, 2'b00, 2'b00, 32'd1, 16'd0);
    vec(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NO, 2'b00, 2'b00, 2'b00, 32'd1, 16'd0);
    idle(C_NO, 2'b00, 2'b00, 2'b00, 32'd1, 16'd0);

    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() > 0) @(posedge clk);
    end
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline hazard controller that sequences the EX stage and its neighbours in the 5-stage RISC-V core.
- Registers forwarding selects for the ALU operand muxes.
- Detects load-use hazards and inserts a bubble.
- Flushes IF/ID on a taken branch resolved in EX.
- Freezes the front end and EX while a multi-cycle EX operation runs.
- Keeps stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- FLUSH_CYCLES, 2, cycles ifid_flush is held after a taken branch (1..15), covering instruction-fetch latency.

Ports:
- clk  in  1  rising-edge clock
- res  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source registers of the ID instruction
- idex_rd  in  REG_AW  destination of the instruction in EX
- idex_reg_write  in  1  EX instruction writes rd
- idex_mem_read  in  1  EX instruction is a load
- exmem_rd  in  REG_AW  destination of the instruction in MEM
- exmem_reg_write  in  1  MEM instruction writes rd
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mc_start  in  1  multi-cycle operation entered EX this cycle
- mc_done  in  1  multi-cycle operation finishes this cycle
- pc_hold  out  1  freeze PC
- ifid_hold  out  1  freeze IF/ID register
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- ex_hold  out  1  freeze ID/EX and EX/MEM
- fwd_a, fwd_b  out  2  operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- state_o  out  2  00 RUN, 01 FLUSH, 10 MC_WAIT
- stall_cnt  out  32  cycles with pc_hold=1, wraps
- flush_cnt  out  16  taken branches accepted, wraps

Behaviour:
- Reset: state RUN, flush counter 0, fwd_a=fwd_b=00, stall_cnt=0, flush_cnt=0. Every combinational output evaluates to 0 while res=1.
- Reset mid-MC_WAIT or mid-FLUSH aborts immediately.
- Hold/flush outputs are Mealy: combinational from the current state and inputs. Everything else is registered.
- RUN, evaluated in priority order:
  - (1) ex_branch_taken=1: ifid_flush=1 and idex_bubble=1 this cycle; flush_cnt+1. If FLUSH_CYCLES>1, go to FLUSH with count FLUSH_CYCLES-1. mc_start and load-use are ignored this cycle.
  - (2) mc_start=1: pc_hold, ifid_hold and ex_hold =1 this cycle; go to MC_WAIT. If mc_done is also 1, no hold and stay in RUN (single-cycle completion).
  - (3) Load-use: id_valid & idex_mem_read & idex_reg_write & idex_rd!=0 & (idex_rd==id_rs1 | idex_rd==id_rs2). Then pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly this cycle; state stays RUN. The hazard clears naturally on the next cycle because the load moves to MEM.
- FLUSH: ifid_flush=1 each cycle; the count decrements; return to RUN when it reaches 1.
  - Load-use detection is suppressed because ID holds a flushed slot.
  - A second ex_branch_taken is impossible (EX holds a bubble) and is ignored.
- MC_WAIT: pc_hold, ifid_hold and ex_hold =1 every cycle until mc_done=1.
  - On the mc_done cycle, all holds are 0 and the next state is RUN.
  - ex_branch_taken and mc_start are ignored in MC_WAIT.
- Forwarding registers:
  - Update on every clk edge where ex_hold=0 and pc_hold=0; otherwise hold their value.
  - Computed for the ID instruction that will enter EX next edge. The current EX instruction becomes EX/MEM; the current MEM instruction becomes MEM/WB.
  - fwd_a: 10 if idex_reg_write & idex_rd!=0 & idex_rd==id_rs1; else 01 if exmem_reg_write & exmem_rd!=0 & exmem_rd==id_rs1; else 00. fwd_b is the same with id_rs2. The newer producer wins.
  - When idex_bubble=1 this cycle, both load 00.
- stall_cnt increments on every edge where pc_hold=1. flush_cnt increments per accepted taken branch only, not per FLUSH cycle. Both wrap modulo 2^width.

Test Plan:
- Reset, then a load with idex_rd=5 in EX and an ID instruction with id_rs2=5 -> exactly one cycle of pc_hold=ifid_hold=idex_bubble=1; stall_cnt=1. Next edge fwd_b=00. After the ID instruction advances, fwd_b=01.
- ALU op with idex_rd=3 in EX, exmem_rd=3 in MEM, ID id_rs1=3 -> fwd_a=10 after the edge. Same with idex_rd=0 -> fwd_a=01.
- ex_branch_taken for 1 cycle with FLUSH_CYCLES=2 -> ifid_flush=1 for 2 cycles, idex_bubble=1 on cycle 1 only, flush_cnt=1, state RUN→FLUSH→RUN. A load-use pattern applied during FLUSH produces no stall.
- mc_start, then mc_done 4 cycles later -> ex_hold=pc_hold=1 for 4 cycles, 0 on the mc_done cycle, stall_cnt=4, fwd_a/fwd_b unchanged throughout.
- ex_branch_taken and mc_start together -> branch flush only, no MC_WAIT. mc_start with mc_done in the same cycle -> no hold.
- Assert res during MC_WAIT on cycle 2 -> all outputs 0 immediately, state_o=00, counters 0. After release, normal operation.
